el2_dec_ib_dbg_seq: RTL and testbench

Sequencer that schedules debug-module register commands (GPR/CSR) into the decode-stage instruction slot shared with the IFU i0 stream. It accepts one command at a time, holds off the IFU, and issues the command to decode once the core is halted and decode can accept. It then waits for completion and returns a one-cycle response. It sits between the debug module and the decode instruction-buffer control, and drives that block's debug-valid and slot-select inputs.

---
 rtl/el2_dec_ib_dbg_seq.sv | 143 ++++++++++++++
 tb/tb_el2_dec_ib_dbg_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/el2_dec_ib_dbg_seq.sv
// Debug register-command sequencer: slots one GPR/CSR command into the decode i0 slot.
// Optional build macro EL2_DBG_CMD_TIMEOUT_EN adds a WAIT_RESP timeout with forced-fail response.
module el2_dec_ib_dbg_seq #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbg_cmd_valid,
  input  logic        dbg_cmd_write,
  input  logic [1:0]  dbg_cmd_type,
  input  logic [31:0] dbg_cmd_addr,
  input  logic        dbg_halted,
  input  logic        dec_stall_d,
  input  logic        dec_dbg_cmd_done,
  input  logic        dec_dbg_cmd_fail,
  output logic        dbg_cmd_ready,
  output logic        dbg_busy,
  output logic        ifu_hold,
  output logic        dbg_sel_d,
  output logic        dbg_issue_d,
  output logic        dbg_fence_d,
  output logic        dbg_resp_valid,
  output logic        dbg_resp_fail
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DRAIN     = 3'd1,
    ISSUE     = 3'd2,
    WAIT_RESP = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic        fail_next;
  logic        timeout_hit;
  logic        fence_cmd;
  logic        cmd_write_reg;
  logic [1:0]  cmd_type_reg;
  logic [31:0] cmd_addr_reg;
  logic        unused_addr_hi;

  // Elaborates only for an illegal timeout configuration, making it visible in the hierarchy.
  if (TIMEOUT_CYCLES < 1 || CNT_W < 1 ||
      (CNT_W < 31 && TIMEOUT_CYCLES >= (1 << CNT_W))) begin : g_bad_timeout_params
    localparam bit PARAMS_BAD = 1'b1;
  end

`ifdef EL2_DBG_CMD_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_reg;

  // The counter holds TIMEOUT_CYCLES-1 in the last WAIT_RESP cycle before the forced exit.
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (state_reg == WAIT_RESP && state_next == WAIT_RESP) begin
      cnt_reg <= cnt_reg + 1'b1;
    end else begin
      cnt_reg <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign dbg_cmd_ready  = ~rst & dbg_cmd_valid & (state_reg == IDLE);
  assign fence_cmd      = cmd_write_reg & (cmd_type_reg == 2'd1) & (cmd_addr_reg[11:0] == 12'h7C4);
  assign unused_addr_hi = ^cmd_addr_reg[31:12];

  always_comb begin
    state_next = state_reg;
    fail_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dbg_cmd_valid) begin
          if (dbg_cmd_type[1]) begin
            state_next = RESP;
            fail_next  = 1'b1;
          end else begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!dbg_halted) begin
          state_next = RESP;
          fail_next  = 1'b1;
        end else if (!dec_stall_d) begin
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT_RESP;
      WAIT_RESP: begin
        // Completion takes priority over a timeout landing in the same cycle.
        if (dec_dbg_cmd_done) begin
          state_next = RESP;
          fail_next  = dec_dbg_cmd_fail;
        end else if (timeout_hit) begin
          state_next = RESP;
          fail_next  = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered decodes of the state being entered, so they line up with state_reg.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cmd_write_reg  <= 1'b0;
      cmd_type_reg   <= 2'd0;
      cmd_addr_reg   <= 32'd0;
      dbg_busy       <= 1'b0;
      ifu_hold       <= 1'b0;
      dbg_sel_d      <= 1'b0;
      dbg_issue_d    <= 1'b0;
      dbg_fence_d    <= 1'b0;
      dbg_resp_valid <= 1'b0;
      dbg_resp_fail  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && dbg_cmd_valid) begin
        cmd_write_reg <= dbg_cmd_write;
        cmd_type_reg  <= dbg_cmd_type;
        cmd_addr_reg  <= dbg_cmd_addr;
      end
      dbg_busy       <= (state_next != IDLE);
      ifu_hold       <= (state_next == DRAIN) || (state_next == ISSUE) || (state_next == WAIT_RESP);
      dbg_sel_d      <= (state_next == ISSUE) || (state_next == WAIT_RESP);
      dbg_issue_d    <= (state_next == ISSUE);
      dbg_fence_d    <= (state_next == ISSUE) && fence_cmd;
      dbg_resp_valid <= (state_next == RESP);
      dbg_resp_fail  <= (state_next == RESP) && fail_next;
    end
  end

endmodule

// File: tb/tb_el2_dec_ib_dbg_seq.sv
// Directed bench for el2_dec_ib_dbg_seq; timeout cases follow EL2_DBG_CMD_TIMEOUT_EN.
module tb_el2_dec_ib_dbg_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbg_cmd_valid;
  logic        dbg_cmd_write;
  logic [1:0]  dbg_cmd_type;
  logic [31:0] dbg_cmd_addr;
  logic        dbg_halted;
  logic        dec_stall_d;
  logic        dec_dbg_cmd_done;
  logic        dec_dbg_cmd_fail;
  logic        dbg_cmd_ready;
  logic        dbg_busy;
  logic        ifu_hold;
  logic        dbg_sel_d;
  logic        dbg_issue_d;
  logic        dbg_fence_d;
  logic        dbg_resp_valid;
  logic        dbg_resp_fail;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  el2_dec_ib_dbg_seq #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .dbg_cmd_valid    (dbg_cmd_valid),
    .dbg_cmd_write    (dbg_cmd_write),
    .dbg_cmd_type     (dbg_cmd_type),
    .dbg_cmd_addr     (dbg_cmd_addr),
    .dbg_halted       (dbg_halted),
    .dec_stall_d      (dec_stall_d),
    .dec_dbg_cmd_done (dec_dbg_cmd_done),
    .dec_dbg_cmd_fail (dec_dbg_cmd_fail),
    .dbg_cmd_ready    (dbg_cmd_ready),
    .dbg_busy         (dbg_busy),
    .ifu_hold         (ifu_hold),
    .dbg_sel_d        (dbg_sel_d),
    .dbg_issue_d      (dbg_issue_d),
    .dbg_fence_d      (dbg_fence_d),
    .dbg_resp_valid   (dbg_resp_valid),
    .dbg_resp_fail    (dbg_resp_fail)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; returns at the falling edge where outputs are stable.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a command for one cycle (handshake cycle N); returns at cycle N+1.
  task automatic send(input logic w, input logic [1:0] t, input logic [31:0] a);
    dbg_cmd_valid = 1'b1;
    dbg_cmd_write = w;
    dbg_cmd_type  = t;
    dbg_cmd_addr  = a;
    #1;
    check("ready_on_handshake", dbg_cmd_ready, 1);
    step();
    dbg_cmd_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    dbg_cmd_valid = 1'b0;
    dbg_cmd_write = 1'b0;
    dbg_cmd_type = 2'd0;
    dbg_cmd_addr = 32'd0;
    dbg_halted = 1'b1;
    dec_stall_d = 1'b0;
    dec_dbg_cmd_done = 1'b0;
    dec_dbg_cmd_fail = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", dbg_cmd_ready, 0);
    check("rst_busy", dbg_busy, 0);
    check("rst_hold", ifu_hold, 0);
    check("rst_sel", dbg_sel_d, 0);
    check("rst_issue", dbg_issue_d, 0);
    check("rst_fence", dbg_fence_d, 0);
    check("rst_resp_valid", dbg_resp_valid, 0);
    check("rst_resp_fail", dbg_resp_fail, 0);
    rst = 1'b0;
    step();

    // GPR read, halted, no stall, done three cycles after issue
    $display("txn 1: GPR read 0x1005");
    send(1'b0, 2'd0, 32'h1005);
    check("t1_hold_n1", ifu_hold, 1);
    check("t1_issue_n1", dbg_issue_d, 0);
    check("t1_busy_n1", dbg_busy, 1);
    step();
    check("t1_issue_n2", dbg_issue_d, 1);
    check("t1_fence_n2", dbg_fence_d, 0);
    check("t1_sel_n2", dbg_sel_d, 1);
    step();
    check("t1_issue_n3", dbg_issue_d, 0);
    check("t1_sel_n3", dbg_sel_d, 1);
    check("t1_resp_n3", dbg_resp_valid, 0);
    step();
    step();
    dec_dbg_cmd_done = 1'b1;
    dec_dbg_cmd_fail = 1'b0;
    step();
    dec_dbg_cmd_done = 1'b0;
    check("t1_resp_n6", dbg_resp_valid, 1);
    check("t1_fail_n6", dbg_resp_fail, 0);
    check("t1_hold_n6", ifu_hold, 0);
    check("t1_sel_n6", dbg_sel_d, 0);
    step();
    check("t1_resp_n7", dbg_resp_valid, 0);
    check("t1_busy_n7", dbg_busy, 0);

    // CSR write to 0x7C4 is a debug fence
    $display("txn 2: CSR write 0x7C4");
    send(1'b1, 2'd1, 32'h0000_07C4);
    step();
    check("t2_issue", dbg_issue_d, 1);
    check("t2_fence", dbg_fence_d, 1);
    step();
    check("t2_fence_after", dbg_fence_d, 0);
    dec_dbg_cmd_done = 1'b1;
    dec_dbg_cmd_fail = 1'b0;
    step();
    dec_dbg_cmd_done = 1'b0;
    check("t2_resp", dbg_resp_valid, 1);
    check("t2_fail", dbg_resp_fail, 0);
    step();

    // Decode stalled for four cycles; a stray done while draining is ignored
    $display("txn 3: CSR read 0x300 with decode stall");
    dec_stall_d = 1'b1;
    send(1'b0, 2'd1, 32'h300);
    for (int i = 1; i <= 4; i++) begin
      check("t3_hold_drain", ifu_hold, 1);
      check("t3_issue_drain", dbg_issue_d, 0);
      dec_dbg_cmd_done = (i == 2);
      dec_dbg_cmd_fail = (i == 2);
      step();
    end
    check("t3_hold_n5", ifu_hold, 1);
    check("t3_issue_n5", dbg_issue_d, 0);
    check("t3_resp_n5", dbg_resp_valid, 0);
    dec_stall_d = 1'b0;
    step();
    check("t3_issue_n6", dbg_issue_d, 1);
    check("t3_fence_n6", dbg_fence_d, 0);
    step();
    dec_dbg_cmd_done = 1'b1;
    dec_dbg_cmd_fail = 1'b1;
    step();
    dec_dbg_cmd_done = 1'b0;
    dec_dbg_cmd_fail = 1'b0;
    check("t3_resp", dbg_resp_valid, 1);
    check("t3_fail", dbg_resp_fail, 1);
    step();

    // Core not halted: fail response two cycles after the handshake, no issue
    $display("txn 4: GPR write with core running");
    dbg_halted = 1'b0;
    send(1'b1, 2'd0, 32'h10);
    check("t4_hold_n1", ifu_hold, 1);
    check("t4_resp_n1", dbg_resp_valid, 0);
    step();
    check("t4_resp_n2", dbg_resp_valid, 1);
    check("t4_fail_n2", dbg_resp_fail, 1);
    check("t4_issue_n2", dbg_issue_d, 0);
    dbg_halted = 1'b1;
    step();

    // Unsupported type: immediate fail; request held while busy; next accepted after the gap
    $display("txn 5: type 2 then type 3 back to back");
    dbg_cmd_valid = 1'b1;
    dbg_cmd_write = 1'b0;
    dbg_cmd_type  = 2'd2;
    dbg_cmd_addr  = 32'h44;
    #1;
    check("t5_ready_n0", dbg_cmd_ready, 1);
    step();
    dbg_cmd_type = 2'd3;
    #1;
    check("t5_ready_busy", dbg_cmd_ready, 0);
    check("t5_resp_n1", dbg_resp_valid, 1);
    check("t5_fail_n1", dbg_resp_fail, 1);
    check("t5_hold_n1", ifu_hold, 0);
    step();
    #1;
    check("t5_ready_gap", dbg_cmd_ready, 1);
    step();
    dbg_cmd_valid = 1'b0;
    #1;
    check("t5_resp_n3", dbg_resp_valid, 1);
    check("t5_fail_n3", dbg_resp_fail, 1);
    check("t5_hold_n3", ifu_hold, 0);
    step();

`ifdef EL2_DBG_CMD_TIMEOUT_EN
    // No completion: forced fail nine cycles after issue
    $display("txn 6: timeout without done");
    send(1'b0, 2'd0, 32'h20);
    step();
    check("t6_issue", dbg_issue_d, 1);
    for (int i = 1; i <= 8; i++) begin
      step();
      check("t6_no_resp_wait", dbg_resp_valid, 0);
    end
    step();
    check("t6_resp", dbg_resp_valid, 1);
    check("t6_fail", dbg_resp_fail, 1);
    step();

    // Done in the timeout cycle wins with its own fail flag
    $display("txn 7: done coincident with timeout");
    send(1'b0, 2'd0, 32'h24);
    step();
    check("t7_issue", dbg_issue_d, 1);
    for (int i = 1; i <= 7; i++) step();
    step();
    check("t7_no_resp_i8", dbg_resp_valid, 0);
    dec_dbg_cmd_done = 1'b1;
    dec_dbg_cmd_fail = 1'b0;
    step();
    dec_dbg_cmd_done = 1'b0;
    check("t7_resp", dbg_resp_valid, 1);
    check("t7_fail", dbg_resp_fail, 0);
    step();
`else
    // Without the timeout, WAIT_RESP only exits on done
    $display("txn 6: long wait without timeout");
    send(1'b0, 2'd0, 32'h20);
    step();
    check("t6_issue", dbg_issue_d, 1);
    for (int i = 1; i <= 12; i++) begin
      step();
      check("t6_no_resp_wait", dbg_resp_valid, 0);
      check("t6_sel_wait", dbg_sel_d, 1);
    end
    dec_dbg_cmd_done = 1'b1;
    dec_dbg_cmd_fail = 1'b0;
    step();
    dec_dbg_cmd_done = 1'b0;
    check("t6_resp", dbg_resp_valid, 1);
    check("t6_fail", dbg_resp_fail, 0);
    step();
`endif

    // Reset during WAIT_RESP aborts with no response
    $display("txn 8: reset in WAIT_RESP");
    send(1'b0, 2'd0, 32'h30);
    step();
    step();
    check("t8_sel_wait", dbg_sel_d, 1);
    rst = 1'b1;
    dbg_cmd_valid = 1'b1;
    #1;
    check("t8_rst_ready", dbg_cmd_ready, 0);
    check("t8_rst_busy", dbg_busy, 0);
    check("t8_rst_hold", ifu_hold, 0);
    check("t8_rst_sel", dbg_sel_d, 0);
    check("t8_rst_resp", dbg_resp_valid, 0);
    dbg_cmd_valid = 1'b0;
    step();
    rst = 1'b0;
    dec_dbg_cmd_done = 1'b1;
    dec_dbg_cmd_fail = 1'b1;
    step();
    dec_dbg_cmd_done = 1'b0;
    dec_dbg_cmd_fail = 1'b0;
    check("t8_no_resp", dbg_resp_valid, 0);
    check("t8_idle_busy", dbg_busy, 0);
    step();
    check("t8_no_resp_late", dbg_resp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
